// File: rtl/vmicro16_timer_multi_apb_pkg.sv
// Register map and control-bit layout shared by the multi-channel timer and its channels.
package vmicro16_timer_multi_apb_pkg;

    typedef enum logic [1:0] {
        REG_LOAD     = 2'd0,
        REG_COUNT    = 2'd1,
        REG_CTRL     = 2'd2,
        REG_PRESCALE = 2'd3
    } chan_reg_e;

    localparam logic [1:0] REG_STATUS = 2'd0;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_WIDTH    = 3;

    // The global block sits at the channel index just past the last channel.
    function automatic int global_block(input int channels);
        return channels;
    endfunction

endpackage

// File: rtl/vmicro16_timer_chan.sv
// One timer channel: prescaler, down-counter and LOAD/CTRL/PRESCALE registers.
module vmicro16_timer_chan
    import vmicro16_timer_multi_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PRE_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_load,
    input  logic                  wr_ctrl,
    input  logic                  wr_prescale,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load,
    output logic [DATA_WIDTH-1:0] count,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [PRE_WIDTH-1:0]  prescale,
    output logic                  fire
);

    logic [PRE_WIDTH-1:0] pre_cnt;
    logic                 run;
    logic                 tick;

    // A LOAD write or a write clearing EN takes the counter out of the running path that cycle.
    assign run  = ctrl[CTRL_EN] && !wr_load && !(wr_ctrl && !wdata[CTRL_EN]);
    assign tick = run && (pre_cnt == '0);
    assign fire = tick && (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load     <= '0;
            count    <= '0;
            ctrl     <= '0;
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            if (wr_prescale)
                prescale <= wdata[PRE_WIDTH-1:0];

            if (wr_load) begin
                load    <= wdata;
                count   <= wdata;
                pre_cnt <= prescale;
            end else if (run) begin
                if (tick) begin
                    pre_cnt <= prescale;
                    if (count != '0)
                        count <= count - DATA_WIDTH'(1);
                    else if (ctrl[CTRL_PERIODIC])
                        count <= load;
                end else begin
                    pre_cnt <= pre_cnt - PRE_WIDTH'(1);
                end
            end

            if (wr_ctrl) begin
                ctrl <= wdata[CTRL_WIDTH-1:0];
                if (!ctrl[CTRL_EN] && wdata[CTRL_EN])
                    pre_cnt <= prescale;
            end else if (fire && !ctrl[CTRL_PERIODIC]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vmicro16_timer_multi_apb.sv
// APB multi-channel timer: address decode, shared STATUS (pending) register and read muxing.
module vmicro16_timer_multi_apb
    import vmicro16_timer_multi_apb_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 16,
    parameter int PRE_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    output logic [CHANNELS-1:0]   out,
    output logic [DATA_WIDTH-1:0] int_data
);

    // Channel field is one bit wider than needed for the channels so it can also name the global block.
    localparam int CH_W  = $clog2(CHANNELS) + 1;
    localparam int IDX_W = CH_W + 2;

    logic [CH_W-1:0] chan_idx;
    logic [1:0]      reg_idx;
    logic            access;
    logic            wr;
    logic            is_global;
    logic            unused_paddr;

    assign chan_idx     = S_PADDR[IDX_W-1:2];
    assign reg_idx      = S_PADDR[1:0];
    assign unused_paddr = ^S_PADDR[BUS_WIDTH-1:IDX_W];
    assign access       = S_PSELx & S_PENABLE;
    assign wr           = access & S_PWRITE;
    assign is_global    = (chan_idx == CH_W'(global_block(CHANNELS)));
    assign S_PREADY     = access;

    logic [DATA_WIDTH-1:0] ch_load  [CHANNELS];
    logic [DATA_WIDTH-1:0] ch_count [CHANNELS];
    logic [CTRL_WIDTH-1:0] ch_ctrl  [CHANNELS];
    logic [PRE_WIDTH-1:0]  ch_pre   [CHANNELS];
    logic [CHANNELS-1:0]   fire;
    logic [CHANNELS-1:0]   irq_en;
    logic [CHANNELS-1:0]   pending;
    logic [CHANNELS-1:0]   clr_mask;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic sel;
        assign sel       = wr && (chan_idx == CH_W'(g));
        assign irq_en[g] = ch_ctrl[g][CTRL_IRQ_EN];

        vmicro16_timer_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .PRE_WIDTH  (PRE_WIDTH)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .wr_load     (sel && (reg_idx == REG_LOAD)),
            .wr_ctrl     (sel && (reg_idx == REG_CTRL)),
            .wr_prescale (sel && (reg_idx == REG_PRESCALE)),
            .wdata       (S_PWDATA),
            .load        (ch_load[g]),
            .count       (ch_count[g]),
            .ctrl        (ch_ctrl[g]),
            .prescale    (ch_pre[g]),
            .fire        (fire[g])
        );
    end

    assign clr_mask = (wr && is_global && (reg_idx == REG_STATUS)) ? S_PWDATA[CHANNELS-1:0] : '0;

    // A fire in the same cycle as a clear of that bit wins, so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else
            pending <= (pending & ~clr_mask) | fire;
    end

    assign out      = pending & irq_en;
    assign int_data = DATA_WIDTH'(pending);

    always_comb begin
        S_PRDATA = '0;
        if (access) begin
            if (is_global) begin
                if (reg_idx == REG_STATUS)
                    S_PRDATA = DATA_WIDTH'(pending);
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (chan_idx == CH_W'(i)) begin
                        case (chan_reg_e'(reg_idx))
                            REG_LOAD:     S_PRDATA = ch_load[i];
                            REG_COUNT:    S_PRDATA = ch_count[i];
                            REG_CTRL:     S_PRDATA = DATA_WIDTH'(ch_ctrl[i]);
                            REG_PRESCALE: S_PRDATA = DATA_WIDTH'(ch_pre[i]);
                            default:      S_PRDATA = '0;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vmicro16_timer_multi_apb.sv
// Self-checking bench: directed timing scenarios plus randomized channels against a closed-form model.
module tb_vmicro16_timer_multi_apb;

    localparam int CHANNELS   = 4;
    localparam int DATA_WIDTH = 16;
    localparam int BUS_WIDTH  = 16;
    localparam int PRE_WIDTH  = 8;
    localparam logic [15:0] STATUS_ADDR = 16'(CHANNELS * 4);

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [BUS_WIDTH-1:0]  S_PADDR = '0;
    logic                  S_PWRITE = 1'b0;
    logic                  S_PSELx = 1'b0;
    logic                  S_PENABLE = 1'b0;
    logic [DATA_WIDTH-1:0] S_PWDATA = '0;
    logic [DATA_WIDTH-1:0] S_PRDATA;
    logic                  S_PREADY;
    logic [CHANNELS-1:0]   out;
    logic [DATA_WIDTH-1:0] int_data;

    always #5 clk = ~clk;

    vmicro16_timer_multi_apb #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .PRE_WIDTH  (PRE_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PSELx   (S_PSELx),
        .S_PENABLE (S_PENABLE),
        .S_PWDATA  (S_PWDATA),
        .S_PRDATA  (S_PRDATA),
        .S_PREADY  (S_PREADY),
        .out       (out),
        .int_data  (int_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Index of the most recent rising edge (rising edges at t = 5, 15, 25, ...).
    function automatic longint edge_idx();
        return longint'(($time - 5) / 10);
    endfunction

    function automatic logic [15:0] addr(input int ch, input int r);
        return 16'(ch * 4 + r);
    endfunction

    task automatic wait_neg(input longint t);
        while (edge_idx() < t) @(negedge clk);
    endtask

    // Called at a falling edge; the write lands on rising edge t.
    task automatic apb_write_at(input longint t, input logic [15:0] a, input logic [15:0] d);
        wait_neg(t - 2);
        S_PSELx = 1'b1; S_PWRITE = 1'b1; S_PENABLE = 1'b0; S_PADDR = a; S_PWDATA = d;
        @(negedge clk);
        S_PENABLE = 1'b1;
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [15:0] d, output longint e);
        e = edge_idx() + 2;
        apb_write_at(e, a, d);
    endtask

    // Returns the read data and the rising edge whose state it reflects.
    task automatic apb_read(input logic [15:0] a, output logic [15:0] d, output longint e);
        S_PSELx = 1'b1; S_PWRITE = 1'b0; S_PENABLE = 1'b0; S_PADDR = a;
        @(negedge clk);
        S_PENABLE = 1'b1;
        #1;
        d = S_PRDATA;
        e = edge_idx();
        check_eq("pready_access", 32'(S_PREADY), 32'd1);
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0;
    endtask

    // Reference model for the random phase: each channel enabled once at edge tc[i].
    longint tc [CHANNELS];
    longint lo [CHANNELS];
    int     m_load [CHANNELS];
    int     m_pre  [CHANNELS];
    bit     m_per  [CHANNELS];
    bit     m_irq  [CHANNELS];

    function automatic longint period(input int i);
        return longint'((m_load[i] + 1) * (m_pre[i] + 1));
    endfunction

    function automatic longint nfires(input int i, input longint t);
        longint n;
        if (t <= tc[i]) return 0;
        n = (t - tc[i]) / period(i);
        if (!m_per[i] && n > 1) n = 1;
        return n;
    endfunction

    function automatic bit m_pending(input int i, input longint t);
        return nfires(i, t) > nfires(i, lo[i] - 1);
    endfunction

    function automatic int m_count(input int i, input longint t);
        longint ticks;
        ticks = (t - tc[i]) / longint'(m_pre[i] + 1);
        if (m_per[i]) return m_load[i] - int'(ticks % longint'(m_load[i] + 1));
        return (ticks >= longint'(m_load[i])) ? 0 : m_load[i] - int'(ticks);
    endfunction

    function automatic logic [15:0] m_bitmap(input longint t, input bit masked);
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < CHANNELS; i++)
            b[i] = m_pending(i, t) && (!masked || m_irq[i]);
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        longint      e, t0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_int_data", 32'(int_data), 32'd0);
        apb_read(addr(0, 0), rd, e);
        check_eq("rst_load0", 32'(rd), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Periodic ch0, W1C race and reload race
        apb_write(addr(0, 3), 16'd1, e);
        apb_write(addr(0, 0), 16'd3, e);
        S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PADDR = addr(0, 0);
        #1;
        check_eq("prdata_setup_phase", 32'(S_PRDATA), 32'd0);
        check_eq("pready_setup_phase", 32'(S_PREADY), 32'd0);
        S_PSELx = 1'b0;
        apb_write(addr(0, 2), 16'h0007, t0);
        wait_neg(t0 + 7);
        check_eq("per_out0_early", 32'(out[0]), 32'd0);
        wait_neg(t0 + 8);
        check_eq("per_out0_fire", 32'(out[0]), 32'd1);
        apb_write_at(t0 + 10, STATUS_ADDR, 16'h0001);
        check_eq("per_cleared", 32'(int_data[0]), 32'd0);
        apb_write_at(t0 + 16, STATUS_ADDR, 16'h0001);
        check_eq("w1c_race_pending", 32'(int_data[0]), 32'd1);
        apb_write_at(t0 + 18, STATUS_ADDR, 16'h0001);
        check_eq("w1c_later_int", 32'(int_data[0]), 32'd0);
        check_eq("w1c_later_out", 32'(out[0]), 32'd0);
        apb_write_at(t0 + 24, addr(0, 0), 16'h0010);
        check_eq("reload_no_fire", 32'(int_data[0]), 32'd0);
        apb_read(addr(0, 1), rd, e);
        check_eq("reload_count", 32'(rd), 32'h10);
        apb_write(addr(0, 2), 16'h0000, e);

        // One-shot ch1
        apb_write(addr(1, 0), 16'd2, e);
        apb_write(addr(1, 2), 16'h0005, t0);
        wait_neg(t0 + 2);
        check_eq("oneshot_early", 32'(int_data[1]), 32'd0);
        wait_neg(t0 + 3);
        check_eq("oneshot_fire", 32'(int_data[1]), 32'd1);
        check_eq("oneshot_out", 32'(out[1]), 32'd1);
        apb_read(addr(1, 2), rd, e);
        check_eq("oneshot_ctrl", 32'(rd), 32'h4);
        repeat (10) @(negedge clk);
        apb_read(addr(1, 1), rd, e);
        check_eq("oneshot_count", 32'(rd), 32'd0);
        apb_write(STATUS_ADDR, 16'h0002, e);
        repeat (10) @(negedge clk);
        check_eq("oneshot_no_refire", 32'(int_data[1]), 32'd0);

        // Masked interrupt on ch2
        apb_write(addr(2, 2), 16'h0003, t0);
        wait_neg(t0 + 1);
        check_eq("masked_int_data", 32'(int_data[2]), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("masked_out", 32'(out[2]), 32'd0);
        apb_write(addr(2, 2), 16'h0000, e);
        apb_write(STATUS_ADDR, 16'h0004, e);
        check_eq("masked_cleared", 32'(int_data), 32'd0);

        // Unmapped access
        apb_read(addr(6, 0), rd, e);
        check_eq("unmapped_chan_read", 32'(rd), 32'd0);
        apb_read(STATUS_ADDR + 16'd1, rd, e);
        check_eq("unmapped_global_read", 32'(rd), 32'd0);

        // Reset mid-run on ch3
        apb_write(addr(3, 0), 16'd11, e);
        apb_write(addr(3, 2), 16'h0007, t0);
        wait_neg(t0 + 4);
        apb_read(addr(3, 1), rd, e);
        check_eq("midrun_count", 32'(rd), 32'd6);
        reset = 1'b0;
        #1;
        check_eq("async_rst_out", 32'(out), 32'd0);
        apb_read(addr(3, 1), rd, e);
        check_eq("rst_count3", 32'(rd), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            apb_read(addr(3, r), rd, e);
            check_eq($sformatf("post_rst_ch3_r%0d", r), 32'(rd), 32'd0);
        end
        apb_read(addr(0, 0), rd, e);
        check_eq("post_rst_load0", 32'(rd), 32'd0);
        repeat (40) @(negedge clk);
        check_eq("post_rst_int_data", 32'(int_data), 32'd0);
        check_eq("post_rst_out", 32'(out), 32'd0);

        // Randomized channels
        for (int i = 0; i < CHANNELS; i++) begin
            m_load[i] = int'($urandom_range(7, 0));
            m_pre[i]  = int'($urandom_range(3, 0));
            m_per[i]  = 1'($urandom_range(1, 0));
            m_irq[i]  = 1'($urandom_range(1, 0));
            lo[i]     = 0;
            apb_write(addr(i, 3), 16'(m_pre[i]), e);
            apb_write(addr(i, 0), 16'(m_load[i]), e);
            apb_write(addr(i, 2), {13'd0, m_irq[i], m_per[i], 1'b1}, tc[i]);
        end
        for (int r = 0; r < 80; r++) begin
            int ch;
            ch = int'($urandom_range(CHANNELS - 1, 0));
            case ($urandom_range(4, 0))
                0: begin
                    apb_read(addr(ch, 1), rd, e);
                    check_eq($sformatf("rnd_count_ch%0d", ch), 32'(rd), 32'(m_count(ch, e)));
                end
                1: begin
                    apb_read(addr(ch, 2), rd, e);
                    check_eq($sformatf("rnd_ctrl_ch%0d", ch), 32'(rd),
                             32'({m_irq[ch], m_per[ch], m_per[ch] || (e - tc[ch] < period(ch))}));
                end
                2: begin
                    check_eq("rnd_int_data", 32'(int_data), 32'(m_bitmap(edge_idx(), 1'b0)));
                    check_eq("rnd_out", 32'(out), 32'(m_bitmap(edge_idx(), 1'b1)));
                end
                3: begin
                    logic [15:0] m;
                    m = 16'($urandom_range(15, 0));
                    apb_write(STATUS_ADDR, m, e);
                    for (int i = 0; i < CHANNELS; i++)
                        if (m[i]) lo[i] = e;
                    check_eq("rnd_after_w1c", 32'(int_data), 32'(m_bitmap(edge_idx(), 1'b0)));
                end
                default: begin
                    apb_write(STATUS_ADDR + 16'd1, 16'hFFFF, e);
                    apb_read(STATUS_ADDR, rd, e);
                    check_eq("rnd_status", 32'(rd), 32'(m_bitmap(e, 1'b0)));
                end
            endcase
            if ($urandom_range(3, 0) == 0)
                repeat ($urandom_range(20, 1)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
